// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: execute-stage request, multiplier handshake and writeback bundle
interface mul_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [1:0]  mul_op_sel;
  logic        mul_in_valid;
  logic        mul_in_ready;
  logic        mul_out_valid;
  logic        mul_out_ready;
  logic [31:0] mul_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        busy;
  modport master (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd,
           mul_in_ready, mul_out_valid, mul_result, wb_ready,
    output req_ready, mul_a, mul_b, mul_op_sel, mul_in_valid, mul_out_ready,
           wb_valid, wb_rd, wb_data, wb_err, busy
  );
  modport slave (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd,
           mul_in_ready, mul_out_valid, mul_result, wb_ready,
    input  req_ready, mul_a, mul_b, mul_op_sel, mul_in_valid, mul_out_ready,
           wb_valid, wb_rd, wb_data, wb_err, busy
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues M-extension multiplies, collects the result pulse and holds it for writeback
module mul_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit BYPASS_ZERO    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mul_issue_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [9:0]  cnt;
  logic [31:0] a_q, b_q, data_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        err_q;
  logic        accept, illegal, zero, tmo;
  always_comb begin
    accept   = state == IDLE && bus.req_valid;
    illegal  = bus.req_funct3[2];
    zero     = BYPASS_ZERO && (bus.req_rs1 == '0 || bus.req_rs2 == '0);
    tmo      = cnt >= 10'(TIMEOUT_CYCLES - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.req_valid ? ((illegal || zero) ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = bus.mul_in_ready ? WAIT : (tmo ? RESP : ISSUE);
      WAIT:    state_nx = (bus.mul_out_valid || tmo) ? RESP : WAIT;
      RESP:    state_nx = bus.wb_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_q    <= bus.req_rs1;
      b_q    <= bus.req_rs2;
      op_q   <= bus.req_funct3[1:0];
      rd_q   <= bus.req_rd;
      data_q <= '0;
      err_q  <= illegal;
    end else if (state == ISSUE || state == WAIT) begin
      cnt <= cnt + 1'b1;
      // a result in the expiry cycle still wins; any other exit to RESP is a timeout
      if (state == WAIT && bus.mul_out_valid) begin
        data_q <= bus.mul_result;
        err_q  <= 1'b0;
      end else if (state_nx == RESP) begin
        err_q <= 1'b1;
      end
    end
  assign bus.req_ready     = state == IDLE;
  assign bus.mul_in_valid  = state == ISSUE;
  assign bus.mul_out_ready = 1'b1;
  assign bus.mul_a         = a_q;
  assign bus.mul_b         = b_q;
  assign bus.mul_op_sel    = op_q;
  assign bus.wb_valid      = state == RESP;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_data       = data_q;
  assign bus.wb_err        = err_q;
  assign bus.busy          = state != IDLE;
endmodule
